// File: rtl/audio_fifo_pkg.sv
// Shared types and constants for the audio sample FIFO.
// Holds the state enum, frame width helper and depth limits.
package audio_fifo_pkg;

    localparam int DEPTH_LOG2_MIN = 2;
    localparam int DEPTH_LOG2_MAX = 6;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int frame_bits(input int width, input int channels);
        return width * channels;
    endfunction

endpackage

// File: rtl/audio_fifo_mem.sv
// Frame storage: one write port, one combinational read port.
// Contents are not reset; pointers in the parent define validity.
module audio_fifo_mem #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];

    // Write the incoming frame at the write address
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/audio_sample_fifo.sv
// Multi-channel audio sample FIFO with prefill and flow flags.
// Optional AUDIO_FIFO_MUTE_EN zeroes the output on underflow.
module audio_sample_fifo
    import audio_fifo_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int CHANNELS   = 2,
    parameter int DEPTH_LOG2 = 3,
    parameter int PREFILL    = 4
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   in_valid,
    input  logic [frame_bits(WIDTH,CHANNELS)-1:0]  in_data,
    input  logic                                   audio_sample,
    output logic [frame_bits(WIDTH,CHANNELS)-1:0]  out_data,
    output logic [DEPTH_LOG2:0]                    level,
    output logic                                   running,
    output logic                                   overflow,
    output logic                                   underflow
);

    localparam int FW = frame_bits(WIDTH, CHANNELS);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] FULL_X = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [PW-1:0] PTR_1  = PW'(1);
    localparam logic [PW-1:0] PRE_LV = PW'(PREFILL);

    if (DEPTH_LOG2 < DEPTH_LOG2_MIN || DEPTH_LOG2 > DEPTH_LOG2_MAX) begin : g_bad_depth
        $error("audio_sample_fifo: DEPTH_LOG2 out of range");
    end

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_level;
    logic [PW-1:0]   w_wr_nxt;
    logic [PW-1:0]   w_rd_nxt;
    logic [FW-1:0]   r_out;
    logic [FW-1:0]   w_rd_data;
    logic            r_ovf;
    logic            r_unf;
    logic            w_empty;
    logic            w_full;
    logic            w_pop_req;
    logic            w_pop;
    logic            w_push;
    logic            w_ovf;
    logic            w_unf;

    // Push/pop qualification and next pointer values
    always_comb begin
        w_empty   = (r_wr_ptr == r_rd_ptr);
        w_full    = ((r_wr_ptr ^ r_rd_ptr) == FULL_X);
        w_pop_req = audio_sample && (r_state == ST_RUN);
        w_pop     = w_pop_req && !w_empty;
        w_push    = in_valid && (!w_full || w_pop);
        w_ovf     = in_valid && !w_push;
        w_unf     = w_pop_req && w_empty;
        w_wr_nxt  = w_push ? r_wr_ptr + PTR_1 : r_wr_ptr;
        w_rd_nxt  = w_pop  ? r_rd_ptr + PTR_1 : r_rd_ptr;
    end

    // Prefill state machine: leave FILL once enough frames stored
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_FILL: if (r_level >= PRE_LV) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_unf)             w_state_nxt = ST_FILL;
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // State, pointers and registered fill level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_FILL;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_level  <= w_wr_nxt - w_rd_nxt;
        end
    end

    // Output frame register and single-cycle flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf;
            r_unf <= w_unf;
            if (w_pop) r_out <= w_rd_data;
`ifdef AUDIO_FIFO_MUTE_EN
            else if (w_unf) r_out <= '0;
`endif
        end
    end

    audio_fifo_mem #(
        .WIDTH      (FW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr[DEPTH_LOG2-1:0]),
        .o_rdata (w_rd_data)
    );

    assign out_data  = r_out;
    assign level     = r_level;
    assign running   = (r_state == ST_RUN);
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

// File: doc/audio_sample_fifo.md
# audio_sample_fifo

Parametrised multi-channel audio sample buffer for the HDMI pixel-clock domain. Accepts already-synchronised sample words on a valid strobe and delivers one frame per `audio_sample` request from the HDMI packetiser. A shallow FIFO with a prefill state machine absorbs producer/consumer jitter. Overflow and underflow are handled deterministically and reported as single-cycle flags.

## Interface
Parameters:
- `WIDTH`, 16: bits per channel sample
- `CHANNELS`, 2: channels per frame; the frame is `WIDTH*CHANNELS` bits with channel 0 in the MSBs
- `DEPTH_LOG2`, 3: FIFO depth is `2**DEPTH_LOG2` frames; legal range 2..6
- `PREFILL`, 4: frames required before leaving FILL; legal range 1..`2**DEPTH_LOG2`

Ports:
- `clk`, in, 1: HDMI pixel clock, 24–80 MHz
- `reset_n`, in, 1: asynchronous active-low reset
- `in_valid`, in, 1: one-cycle push strobe
- `in_data`, in, `WIDTH*CHANNELS`: frame to push
- `audio_sample`, in, 1: one-cycle pop request
- `out_data`, out, `WIDTH*CHANNELS`: current output frame, registered
- `level`, out, `DEPTH_LOG2+1`: stored frame count, 0..`2**DEPTH_LOG2`
- `running`, out, 1: state is RUN
- `overflow`, out, 1: one-cycle pulse when a push is dropped
- `underflow`, out, 1: one-cycle pulse when a pop finds the FIFO empty in RUN

## Operation
- Storage: circular buffer with `DEPTH_LOG2+1`-bit write and read pointers; pointer MSB distinguishes full from empty; pointers wrap modulo `2**(DEPTH_LOG2+1)`.
- Push: when `in_valid` is high and the FIFO is not full, write at `wr_ptr` and increment it.
- Push while full without a same-cycle pop: drop the incoming frame, leave storage unchanged, pulse `overflow`.
- Push while full with a same-cycle pop: both succeed, no overflow, `level` unchanged.
- States:
  - FILL: `audio_sample` is ignored, nothing is popped, `out_data` is held per Configuration. Go to RUN in the cycle after `level >= PREFILL`.
  - RUN: each `audio_sample` pops the frame at `rd_ptr` into `out_data`.
- Pop while empty in RUN: `out_data` is held or muted per Configuration, `underflow` pulses, state returns to FILL. A same-cycle push is still written.
- `level = wr_ptr - rd_ptr`, registered.
- `audio_sample` and `in_valid` are each assumed to be at most one cycle wide. A held-high input counts once per cycle.

## Timing
- Reset values: `out_data` = 0, `level` = 0, `running` = 0, `overflow` = 0, `underflow` = 0, pointers = 0, state = FILL.
- `out_data` updates on the clock edge after the cycle in which `audio_sample` is high: one-cycle latency.
- `level` reflects a push or pop one cycle after the strobe.
- `overflow` and `underflow` assert in the cycle after the offending strobe, for exactly one cycle.
- The FILL→RUN transition takes one cycle after the threshold is reached. The first pop can be accepted in the cycle `running` is high.
- `reset_n` asserted mid-operation clears all state immediately; stored frames are discarded. Deassertion is synchronised externally.

## Configuration
- `AUDIO_FIFO_MUTE_EN` defined: on entry to FILL, and for every pop that finds the FIFO empty, `out_data` is forced to all zeros. Output is silent until RUN resumes.
- `AUDIO_FIFO_MUTE_EN` undefined: `out_data` holds the last popped frame through FILL and on underflow (sample repeat, no click).

## Structure
- Package `audio_fifo_pkg`:
  - state enum `{ST_FILL, ST_RUN}`
  - function `frame_bits(WIDTH, CHANNELS)`
  - legal-range constants for `DEPTH_LOG2`
- Sub-module `audio_fifo_mem`: simple dual-port register array with one write port and one read port, combinational read, no reset on contents.
- The top level holds pointers, the state machine and flags.

## Test plan
- Reset, push 4 frames `0x0001_0001`..`0x0004_0004`, then pulse `audio_sample` 4 times → `running` rises after the 4th push; `out_data` = `0x0001_0001`..`0x0004_0004` in order, each one cycle after its pop.
- Push 9 frames with no pops, `DEPTH_LOG2=3` → `level` = 8, a single `overflow` pulse on the 9th push, and the 9th frame never appears at the output.
- In RUN with `level=8`, push and pop in the same cycle → `level` stays 8, no `overflow`, and the output is the oldest frame.
- Drain to empty, then pulse `audio_sample` → `underflow` pulses, `running` drops, and `out_data` is either the last frame (macro off) or `0x0000_0000` (macro on); further pops are ignored until 4 new pushes.
- Assert `reset_n` low with `level=5` mid-stream → all outputs return to 0 asynchronously; after release, `level=0` and state is FILL.
- Run with `CHANNELS=6`, `WIDTH=24` and random push/pop with balanced rates → the output frame sequence equals the input sequence, compared against a scoreboard.
